// File: rtl/gpio_mmio_port.sv
// Memory-mapped GPIO peripheral: per-bit direction, 2-FF input sync, edge detect
// and a sticky, maskable interrupt. Decoded as a 32-byte window on the data bus.
module gpio_mmio_port #(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           GPIO_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] BASE_ADDR  = 32'h1001_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] Address_i,
  input  logic                  Write_Enable_i,
  input  logic [DATA_WIDTH-1:0] Write_Data_i,
  output logic [DATA_WIDTH-1:0] Read_Data_o,
  output logic                  Hit_o,
  input  logic [GPIO_WIDTH-1:0] GPIO_i,
  output logic [GPIO_WIDTH-1:0] GPIO_o,
  output logic [GPIO_WIDTH-1:0] GPIO_oe_o,
  output logic                  IRQ_o
);

  localparam logic [2:0] OFF_OUT     = 3'd0;
  localparam logic [2:0] OFF_IN      = 3'd1;
  localparam logic [2:0] OFF_DIR     = 3'd2;
  localparam logic [2:0] OFF_RISE_EN = 3'd3;
  localparam logic [2:0] OFF_FALL_EN = 3'd4;
  localparam logic [2:0] OFF_STATUS  = 3'd5;
  localparam logic [2:0] OFF_IRQ_EN  = 3'd6;

  logic [GPIO_WIDTH-1:0] out_q, out_d;
  logic [GPIO_WIDTH-1:0] dir_q, dir_d;
  logic [GPIO_WIDTH-1:0] rise_en_q, rise_en_d;
  logic [GPIO_WIDTH-1:0] fall_en_q, fall_en_d;
  logic [GPIO_WIDTH-1:0] status_q, status_d;
  logic [GPIO_WIDTH-1:0] irq_en_q, irq_en_d;
  logic [GPIO_WIDTH-1:0] s1_q, s2_q, prev_q;
  logic [1:0]            arm_q, arm_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic [2:0]            offset;
  logic                  wr;
  logic                  armed;
  logic [GPIO_WIDTH-1:0] wdata, edge_mask, rise, fall, w1c, rd_sel;
  logic                  unused_bits;

  assign unused_bits = &{1'b0, Address_i[1:0], Write_Data_i};

  assign Hit_o       = (Address_i[DATA_WIDTH-1:5] == BASE_ADDR[DATA_WIDTH-1:5]);
  assign Read_Data_o = rdata_q;
  assign GPIO_o      = out_q;
  assign GPIO_oe_o   = dir_q;
  assign IRQ_o       = |(status_q & irq_en_q);

  always_comb begin
    offset    = Address_i[4:2];
    wr        = Hit_o & Write_Enable_i;
    wdata     = Write_Data_i[GPIO_WIDTH-1:0];
    // Edges are ignored until the sync/prev pipeline has refilled after reset.
    armed     = (arm_q == 2'd3);
    arm_d     = armed ? arm_q : arm_q + 2'd1;
    edge_mask = ~dir_q & {GPIO_WIDTH{armed}};
    rise      = s2_q & ~prev_q & rise_en_q & edge_mask;
    fall      = ~s2_q & prev_q & fall_en_q & edge_mask;

    out_d     = out_q;
    dir_d     = dir_q;
    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;
    irq_en_d  = irq_en_q;
    w1c       = '0;
    if (wr) begin
      case (offset)
        OFF_OUT:     out_d     = wdata;
        OFF_DIR:     dir_d     = wdata;
        OFF_RISE_EN: rise_en_d = wdata;
        OFF_FALL_EN: fall_en_d = wdata;
        OFF_STATUS:  w1c       = wdata;
        OFF_IRQ_EN:  irq_en_d  = wdata;
        default:     ;
      endcase
    end
    // Set terms are OR'd after the clear so a coincident edge survives W1C.
    status_d = (status_q & ~w1c) | rise | fall;

    rd_sel = '0;
    case (offset)
      OFF_OUT:     rd_sel = out_q;
      OFF_IN:      rd_sel = s2_q;
      OFF_DIR:     rd_sel = dir_q;
      OFF_RISE_EN: rd_sel = rise_en_q;
      OFF_FALL_EN: rd_sel = fall_en_q;
      OFF_STATUS:  rd_sel = status_q;
      OFF_IRQ_EN:  rd_sel = irq_en_q;
      default:     rd_sel = '0;
    endcase
    rdata_d = '0;
    if (Hit_o) rdata_d[GPIO_WIDTH-1:0] = rd_sel;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_q     <= '0;
      dir_q     <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
      status_q  <= '0;
      irq_en_q  <= '0;
      s1_q      <= '0;
      s2_q      <= '0;
      prev_q    <= '0;
      arm_q     <= '0;
      rdata_q   <= '0;
    end else begin
      out_q     <= out_d;
      dir_q     <= dir_d;
      rise_en_q <= rise_en_d;
      fall_en_q <= fall_en_d;
      status_q  <= status_d;
      irq_en_q  <= irq_en_d;
      s1_q      <= GPIO_i;
      s2_q      <= s1_q;
      prev_q    <= s2_q;
      arm_q     <= arm_d;
      rdata_q   <= rdata_d;
    end
  end

endmodule

// File: tb/tb_gpio_mmio_port.sv
// Directed bench for gpio_mmio_port: reset arming, register access, sync latency,
// edge/IRQ behaviour, W1C-vs-edge priority, address decode and mid-run reset.
module tb_gpio_mmio_port;

  localparam logic [31:0] BASE = 32'h1001_0000;
  localparam logic [31:0] A_OUT = BASE + 32'h00, A_IN = BASE + 32'h04, A_DIR = BASE + 32'h08;
  localparam logic [31:0] A_RISE = BASE + 32'h0C, A_FALL = BASE + 32'h10;
  localparam logic [31:0] A_STAT = BASE + 32'h14, A_IRQEN = BASE + 32'h18, A_RSVD = BASE + 32'h1C;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Address_i, Write_Data_i, Read_Data_o;
  logic        Write_Enable_i, Hit_o, IRQ_o;
  logic [7:0]  GPIO_i, GPIO_o, GPIO_oe_o;

  int checks = 0;
  int errors = 0;
  logic [31:0] rd;

  gpio_mmio_port dut (
    .clk            (clk),
    .reset          (reset),
    .Address_i      (Address_i),
    .Write_Enable_i (Write_Enable_i),
    .Write_Data_i   (Write_Data_i),
    .Read_Data_o    (Read_Data_o),
    .Hit_o          (Hit_o),
    .GPIO_i         (GPIO_i),
    .GPIO_o         (GPIO_o),
    .GPIO_oe_o      (GPIO_oe_o),
    .IRQ_o          (IRQ_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance past one rising edge; all driving and sampling happens 1 ns later.
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
    Address_i      = addr;
    Write_Data_i   = data;
    Write_Enable_i = 1'b1;
    tick();
    Write_Enable_i = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
    Address_i      = addr;
    Write_Enable_i = 1'b0;
    tick();
    data = Read_Data_o;
  endtask

  initial begin
    reset          = 1'b1;
    Address_i      = A_OUT;
    Write_Data_i   = '0;
    Write_Enable_i = 1'b0;
    GPIO_i         = 8'hFF;
    tick(3);
    chk("rst_rdata", Read_Data_o, 32'h0);
    chk("rst_gpio_o", {24'h0, GPIO_o}, 32'h0);
    chk("rst_oe", {24'h0, GPIO_oe_o}, 32'h0);
    chk("rst_irq", {31'h0, IRQ_o}, 32'h0);

    // T1: pins held high across reset must not produce rising edges.
    reset = 1'b0;
    bus_write(A_RISE, 32'hFF);
    bus_write(A_IRQEN, 32'hFF);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t1_irq", {31'h0, IRQ_o}, 32'h0);
    end
    bus_read(A_STAT, rd);
    chk("t1_status", rd, 32'h0);
    bus_write(A_RISE, 32'h00);
    bus_write(A_IRQEN, 32'h00);
    GPIO_i = 8'h00;
    tick(4);

    // T2: output and direction registers.
    bus_write(A_OUT, 32'hA5);
    chk("t2_gpio_o", {24'h0, GPIO_o}, 32'hA5);
    chk("t2_oe_before", {24'h0, GPIO_oe_o}, 32'h00);
    bus_write(A_DIR, 32'h0F);
    chk("t2_oe", {24'h0, GPIO_oe_o}, 32'h0F);
    bus_read(A_OUT, rd);
    chk("t2_rd_out", rd, 32'h0000_00A5);
    bus_read(A_DIR, rd);
    chk("t2_rd_dir", rd, 32'h0000_000F);
    bus_write(A_DIR, 32'h00);

    // T3: IN visible two edges after the pin change, read data one edge later.
    GPIO_i = 8'h3C;
    tick();
    bus_read(A_IN, rd);
    chk("t3_in_early", rd, 32'h0);
    bus_read(A_IN, rd);
    chk("t3_in", rd, 32'h3C);
    GPIO_i = 8'h00;
    tick(4);

    // T4: rising edge on bit 0 raises IRQ after edge k+2; W1C clears it.
    bus_write(A_RISE, 32'h01);
    bus_write(A_IRQEN, 32'h01);
    GPIO_i = 8'h01;
    tick();
    chk("t4_irq_k", {31'h0, IRQ_o}, 32'h0);
    tick();
    chk("t4_irq_k1", {31'h0, IRQ_o}, 32'h0);
    tick();
    chk("t4_irq_k2", {31'h0, IRQ_o}, 32'h1);
    bus_read(A_STAT, rd);
    chk("t4_status", rd, 32'h01);
    bus_write(A_STAT, 32'h01);
    chk("t4_irq_clr", {31'h0, IRQ_o}, 32'h0);
    bus_read(A_STAT, rd);
    chk("t4_status_clr", rd, 32'h0);

    // T5: W1C coincident with a new falling edge on bit 1 leaves the bit set.
    bus_write(A_FALL, 32'h02);
    GPIO_i = 8'h03;
    tick(4);
    GPIO_i = 8'h01;
    tick(3);
    bus_read(A_STAT, rd);
    chk("t5_fall_set", rd, 32'h02);
    GPIO_i = 8'h03;
    tick(4);
    GPIO_i = 8'h01;
    tick(2);
    bus_write(A_STAT, 32'h02);
    bus_read(A_STAT, rd);
    chk("t5_edge_wins", rd, 32'h02);
    chk("t5_irq_masked", {31'h0, IRQ_o}, 32'h0);
    bus_write(A_STAT, 32'h02);
    bus_read(A_STAT, rd);
    chk("t5_w1c", rd, 32'h00);

    // Output bits ignore edges, and returning them to input does not fake one.
    bus_write(A_DIR, 32'h02);
    GPIO_i = 8'h03;
    tick(4);
    GPIO_i = 8'h01;
    tick(4);
    bus_read(A_STAT, rd);
    chk("dir_masked", rd, 32'h00);
    bus_write(A_DIR, 32'h00);
    tick(3);
    bus_read(A_STAT, rd);
    chk("dir_release", rd, 32'h00);

    // T6: out-of-window and reserved accesses.
    Address_i = BASE + 32'h40;
    #1;
    chk("t6_nohit", {31'h0, Hit_o}, 32'h0);
    Address_i = A_OUT;
    #1;
    chk("t6_hit", {31'h0, Hit_o}, 32'h1);
    bus_write(BASE + 32'h40, 32'hFF);
    chk("t6_gpio_o", {24'h0, GPIO_o}, 32'hA5);
    bus_read(BASE + 32'h40, rd);
    chk("t6_rd_miss", rd, 32'h0);
    bus_read(A_OUT, rd);
    chk("t6_rd_out", rd, 32'hA5);
    bus_write(A_RSVD, 32'hFF);
    bus_read(A_RSVD, rd);
    chk("t6_rd_rsvd", rd, 32'h0);
    bus_write(A_IN, 32'hFF);
    bus_read(A_IN, rd);
    chk("t6_in_ro", rd, 32'h01);

    // Mid-run reset drops a pending IRQ and clears the pad controls.
    GPIO_i = 8'h00;
    tick(4);
    GPIO_i = 8'h01;
    tick(3);
    chk("mr_irq_set", {31'h0, IRQ_o}, 32'h1);
    reset = 1'b1;
    tick();
    chk("mr_irq_clr", {31'h0, IRQ_o}, 32'h0);
    chk("mr_gpio_o", {24'h0, GPIO_o}, 32'h0);
    reset = 1'b0;
    tick(4);
    bus_read(A_STAT, rd);
    chk("mr_status", rd, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
